// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable 32-bit data memory behind a req/ready handshake.
// Four byte-lane RAM arrays. Stores and loads may be byte, half or word wide,
// and loads are sign- or zero-extended. Misaligned or reserved-size accesses
// are flagged. Response latency is set by LATENCY.
//
// Timing: a request is accepted at edge t0. The FSM passes through WAIT, and
// DONE is the state held in the cycle before edge t0+LATENCY. At that edge the
// access completes: a store commits to RAM, a load samples RAM, and mem_ready
// pulses for one cycle. Because the FSM is already back in IDLE while
// mem_ready is high, a request held high is accepted again at t0+LATENCY+1.
module data_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_i,
  output logic        mem_ready,
  output logic [31:0] mem_data_o,
  output logic        mem_misalign
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        count_q;
  logic                    wen_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [1:0]              lane_q;
  logic [ADDR_WIDTH-1:0]   widx_q;
  logic [31:0]             wdata_q;
  logic                    mem_ready_q;
  logic [31:0]             mem_data_q;
  logic                    mem_misalign_q;

  // byte-lane storage, lane 0 holds bits [7:0] of each word
  logic [7:0]              ram_q [LANES][DEPTH];

  logic                    misalign_d;
  logic [LANES-1:0]        be_d;
  logic [31:0]             wlane_d;
  logic                    wr_en_d;
  logic [31:0]             rword_d;
  logic [7:0]              rbyte_d;
  logic [15:0]             rhalf_d;
  logic [31:0]             load_d;
  logic [31:0]             rdata_d;

  // address bits above the word index are ignored, so the memory wraps
  logic                    unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[31:ADDR_WIDTH+2];

  // alignment check on the latched access
  always_comb begin
    misalign_d = 1'b0;
    case (size_q)
      SZ_BYTE: misalign_d = 1'b0;
      SZ_HALF: misalign_d = lane_q[0];
      SZ_WORD: misalign_d = (lane_q != 2'b00);
      default: misalign_d = 1'b1;
    endcase
  end

  // byte enables and lane-replicated store data for the latched store
  always_comb begin
    be_d    = '0;
    wlane_d = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        be_d    = 4'(4'b0001 << lane_q);
        wlane_d = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be_d    = lane_q[1] ? 4'b1100 : 4'b0011;
        wlane_d = {2{wdata_q[15:0]}};
      end
      SZ_WORD: begin
        be_d    = 4'b1111;
        wlane_d = wdata_q;
      end
      default: begin
        be_d    = 4'b0000;
        wlane_d = wdata_q;
      end
    endcase
  end

  // a store commits only on the completing edge and only when aligned
  always_comb begin
    wr_en_d = (state_q == DONE) && wen_q && !misalign_d;
  end

  // load path: read the addressed word, extract the lane(s), then extend
  always_comb begin
    rword_d = {ram_q[3][widx_q], ram_q[2][widx_q], ram_q[1][widx_q], ram_q[0][widx_q]};
    rbyte_d = rword_d[7:0];
    case (lane_q)
      2'd0:    rbyte_d = rword_d[7:0];
      2'd1:    rbyte_d = rword_d[15:8];
      2'd2:    rbyte_d = rword_d[23:16];
      default: rbyte_d = rword_d[31:24];
    endcase
    rhalf_d = lane_q[1] ? rword_d[31:16] : rword_d[15:0];
    load_d  = rword_d;
    case (size_q)
      SZ_BYTE: load_d = uns_q ? {24'd0, rbyte_d} : {{24{rbyte_d[7]}}, rbyte_d};
      SZ_HALF: load_d = uns_q ? {16'd0, rhalf_d} : {{16{rhalf_d[15]}}, rhalf_d};
      default: load_d = rword_d;
    endcase
    rdata_d = (wen_q || misalign_d) ? 32'd0 : load_d;
  end

  // RAM lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (be_d[l]) begin
          ram_q[l][widx_q] <= wlane_d[8*l +: 8];
        end
      end
    end
  end

  // handshake FSM: accept in IDLE, count out the latency, complete with a ready pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      count_q        <= '0;
      wen_q          <= 1'b0;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      lane_q         <= 2'b00;
      widx_q         <= '0;
      wdata_q        <= '0;
      mem_ready_q    <= 1'b0;
      mem_data_q     <= '0;
      mem_misalign_q <= 1'b0;
    end else begin
      mem_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            wen_q   <= mem_wen;
            size_q  <= mem_size;
            uns_q   <= mem_unsigned;
            lane_q  <= mem_addr[1:0];
            widx_q  <= mem_addr[ADDR_WIDTH+1:2];
            wdata_q <= mem_data_i;
            if (LATENCY <= 1) begin
              state_q <= DONE;
              count_q <= '0;
            end else begin
              state_q <= WAIT;
              count_q <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (count_q <= CNT_W'(1)) begin
            state_q <= DONE;
            count_q <= '0;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q        <= IDLE;
          mem_ready_q    <= 1'b1;
          mem_data_q     <= rdata_d;
          mem_misalign_q <= misalign_d;
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign mem_ready    = mem_ready_q;
  assign mem_data_o   = mem_data_q;
  assign mem_misalign = mem_misalign_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: three instances (LATENCY 1/4/3, ADDR_WIDTH 16/4/8)
// checked against a byte-array reference model of the memory.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic        wen = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [2:0]  rdy;
  logic [2:0]  mis;
  logic [31:0] rdo [3];

  int errors = 0;
  int checks = 0;
  int lat_tab [3];
  int aw_tab  [3];
  logic [7:0] mdl [int];

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(16), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .mem_req(req[0]), .mem_wen(wen), .mem_size(size),
    .mem_unsigned(uns), .mem_addr(addr), .mem_data_i(wdata),
    .mem_ready(rdy[0]), .mem_data_o(rdo[0]), .mem_misalign(mis[0]));

  data_mem_ctrl #(.ADDR_WIDTH(4), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .mem_req(req[1]), .mem_wen(wen), .mem_size(size),
    .mem_unsigned(uns), .mem_addr(addr), .mem_data_i(wdata),
    .mem_ready(rdy[1]), .mem_data_o(rdo[1]), .mem_misalign(mis[1]));

  data_mem_ctrl #(.ADDR_WIDTH(8), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .mem_req(req[2]), .mem_wen(wen), .mem_size(size),
    .mem_unsigned(uns), .mem_addr(addr), .mem_data_i(wdata),
    .mem_ready(rdy[2]), .mem_data_o(rdo[2]), .mem_misalign(mis[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // model key: instance in the upper bits, byte address modulo memory size below
  function automatic int key(input int k, input logic [31:0] a);
    logic [31:0] m;
    m = (32'd4 << aw_tab[k]) - 32'd1;
    return (k << 20) | int'(a & m);
  endfunction

  // reference behaviour of one access; updates the model for aligned stores
  task automatic model(input int k, input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic em, output logic [31:0] ed, output bit known);
    int nb;
    logic [31:0] v;
    em = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ed = 32'd0;
    known = 1'b1;
    if (em) return;
    if (w) begin
      for (int i = 0; i < nb; i++) mdl[key(k, a + 32'(i))] = d[8*i +: 8];
      return;
    end
    v = 32'd0;
    for (int i = 0; i < nb; i++) begin
      if (mdl.exists(key(k, a + 32'(i)))) v[8*i +: 8] = mdl[key(k, a + 32'(i))];
      else known = 1'b0;
    end
    if (nb == 1)      ed = u ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
    else if (nb == 2) ed = u ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    else              ed = v;
  endtask

  // one request on instance k: checks latency, misalign flag, data and single-cycle pulse
  task automatic access(input int k, input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    logic em;
    logic [31:0] ed;
    bit kn;
    int n;
    model(k, w, sz, u, a, d, em, ed, kn);
    @(negedge clk);
    wen = w; size = sz; uns = u; addr = a; wdata = d;
    req[k] = 1'b1;
    @(negedge clk);
    req[k] = 1'b0;
    n = 0;
    while (!rdy[k] && n < 24) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat_tab[k]));
    chk({tag, ".mis"}, 32'(mis[k]), 32'(em));
    if (kn) chk({tag, ".data"}, rdo[k], ed);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(rdy[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    bit seen;
    logic [31:0] a;
    logic [1:0] sz;
    int r;

    lat_tab[0] = 1; lat_tab[1] = 4; lat_tab[2] = 3;
    aw_tab[0]  = 16; aw_tab[1] = 4; aw_tab[2] = 8;

    // reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst.ready%0d", k), 32'(rdy[k]), 32'd0);
      chk($sformatf("rst.data%0d", k), rdo[k], 32'd0);
      chk($sformatf("rst.mis%0d", k), 32'(mis[k]), 32'd0);
    end
    rst = 1'b0;

    // LATENCY=1 directed sequence
    access(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, "sw10");
    access(0, 0, 2'd2, 0, 32'h10, 32'h0, "lw10");
    chk("lw10.const", rdo[0], 32'hDEADBEEF);
    access(0, 1, 2'd0, 0, 32'h13, 32'h00000080, "sb13");
    access(0, 0, 2'd0, 0, 32'h13, 32'h0, "lb13");
    chk("lb13.const", rdo[0], 32'hFFFFFF80);
    access(0, 0, 2'd0, 1, 32'h13, 32'h0, "lbu13");
    chk("lbu13.const", rdo[0], 32'h00000080);
    access(0, 0, 2'd2, 0, 32'h10, 32'h0, "lw10b");
    chk("lw10b.const", rdo[0], 32'h80ADBEEF);
    access(0, 1, 2'd1, 0, 32'h22, 32'h00001234, "sh22");
    access(0, 0, 2'd1, 0, 32'h22, 32'h0, "lh22");
    chk("lh22.const", rdo[0], 32'h00001234);
    access(0, 0, 2'd1, 0, 32'h21, 32'h0, "lh21");
    chk("lh21.mis", 32'(mis[0]), 32'd1);
    chk("lh21.zero", rdo[0], 32'd0);
    access(0, 1, 2'd2, 0, 32'h24, 32'h55667788, "sw24");
    access(0, 1, 2'd2, 0, 32'h26, 32'hFFFFFFFF, "sw26");
    chk("sw26.mis", 32'(mis[0]), 32'd1);
    access(0, 0, 2'd2, 0, 32'h24, 32'h0, "lw24");
    chk("lw24.const", rdo[0], 32'h55667788);
    access(0, 0, 2'd3, 0, 32'h20, 32'h0, "sz3");
    chk("sz3.mis", 32'(mis[0]), 32'd1);
    access(0, 0, 2'd1, 1, 32'h22, 32'h0, "lhu22");

    // ADDR_WIDTH=4 wrap on the LATENCY=4 instance
    access(1, 1, 2'd2, 0, 32'h40, 32'hA5A5A5A5, "sw40");
    access(1, 0, 2'd2, 0, 32'h00, 32'h0, "lw00");
    chk("wrap.const", rdo[1], 32'hA5A5A5A5);

    // LATENCY=4 with mem_req held high: accepts at edges 0 and 5 only
    @(negedge clk);
    wen = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h0; req[1] = 1'b1;
    @(negedge clk);
    n = 0;
    while (!rdy[1] && n < 24) begin
      @(negedge clk);
      n++;
    end
    chk("hold.first", 32'(n), 32'd4);
    chk("hold.data1", rdo[1], 32'hA5A5A5A5);
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!rdy[1] && m < 24);
    req[1] = 1'b0;
    chk("hold.second", 32'(m), 32'd5);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rdy[1]) seen = 1'b1;
    end
    chk("hold.nothird", 32'(seen), 32'd0);

    // randomized traffic, LATENCY=1 region with random high address bits
    for (int i = 0; i < 16; i++)
      access(0, 1, 2'd2, 0, 32'h100 + 32'(4*i), $urandom, $sformatf("init0.%0d", i));
    for (int i = 0; i < 40; i++) begin
      r  = int'($urandom_range(0, 7));
      sz = (r == 7) ? 2'd3 : 2'(r % 3);
      a  = ($urandom & 32'hFFFC0000) | (32'h100 + 32'($urandom_range(0, 63)));
      access(0, 1'($urandom), sz, 1'($urandom), a, $urandom, $sformatf("rnd0.%0d", i));
    end

    // randomized traffic over full 32-bit addresses on the wrapping instance
    for (int i = 0; i < 16; i++)
      access(1, 1, 2'd2, 0, 32'(4*i), $urandom, $sformatf("init1.%0d", i));
    for (int i = 0; i < 20; i++) begin
      r  = int'($urandom_range(0, 7));
      sz = (r == 7) ? 2'd3 : 2'(r % 3);
      access(1, 1'($urandom), sz, 1'($urandom), $urandom, $urandom, $sformatf("rnd1.%0d", i));
    end

    // LATENCY=3: reset during a pending store discards it
    access(2, 1, 2'd2, 0, 32'h30, 32'h11223344, "sw30");
    access(2, 0, 2'd2, 0, 32'h30, 32'h0, "lw30");
    chk("lw30.const", rdo[2], 32'h11223344);
    @(negedge clk);
    wen = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h30; wdata = 32'hCAFEF00D;
    req[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstmid.data", rdo[2], 32'd0);
    chk("rstmid.ready", 32'(rdy[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rdy[2]) seen = 1'b1;
    end
    chk("rstmid.noready", 32'(seen), 32'd0);
    chk("rstmid.mis", 32'(mis[2]), 32'd0);
    chk("rstmid.data2", rdo[2], 32'd0);
    access(2, 0, 2'd2, 0, 32'h30, 32'h0, "lw30b");
    chk("lw30b.const", rdo[2], 32'h11223344);
    access(2, 0, 2'd0, 0, 32'h31, 32'h0, "lb31");
    chk("lb31.const", rdo[2], 32'h00000033);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
